// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer with flag register and branch resolution.
// Optional STICKY_OVF_EN adds a sticky overflow bit (ovf_sticky / ovf_clr).
module alu_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RDW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_zout,
    input  logic             in_n,
    input  logic             in_v,
    input  logic [2:0]       in_gin,
    input  logic [RDW-1:0]   in_rd,
    input  logic             in_regwrite,
    input  logic             in_setflags,
    input  logic [2:0]       in_br,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [RDW-1:0]   out_rd,
    output logic             out_regwrite,
    output logic [2:0]       flags_q,
    output logic             br_taken,
    output logic             illegal_op
`ifdef STICKY_OVF_EN
    ,
    output logic             ovf_sticky,
    input  logic             ovf_clr
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [RDW-1:0]   rd;
        logic             regwrite;
    } entry_t;

    entry_t      mem_q [2];
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  count_q, count_d;
    logic [2:0]  flags_d;
    logic        br_taken_q, br_taken_d;
    logic        illegal_q, illegal_d;

    logic        legal_c;
    logic        accept_c;
    logic        pop_c;
    logic        br_cond_c;
    entry_t      new_entry_c;

    assign in_ready     = (count_q != 2'd2);
    assign out_valid    = (count_q != 2'd0);
    assign out_sum      = mem_q[head_q].sum;
    assign out_rd       = mem_q[head_q].rd;
    assign out_regwrite = mem_q[head_q].regwrite;
    assign br_taken     = br_taken_q;
    assign illegal_op   = illegal_q;

    // Decode of incoming entry: legality, branch condition, handshake.
    always_comb begin
        legal_c   = 1'b0;
        br_cond_c = 1'b0;
        case (in_gin)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: legal_c = 1'b1;
            default:                                legal_c = 1'b0;
        endcase
        case (in_br)
            3'b001:  br_cond_c = in_zout;
            3'b010:  br_cond_c = ~in_zout;
            3'b011:  br_cond_c = in_n;
            3'b100:  br_cond_c = in_v;
            default: br_cond_c = 1'b0;
        endcase
        accept_c             = in_valid && in_ready && !flush;
        pop_c                = out_valid && out_ready;
        new_entry_c.sum      = in_sum;
        new_entry_c.rd       = in_rd;
        new_entry_c.regwrite = in_regwrite && legal_c;
    end

    // Next-state for pointers, occupancy, flags and one-cycle pulses.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        flags_d    = flags_q;
        br_taken_d = 1'b0;
        illegal_d  = 1'b0;
        if (flush) begin
            head_d  = 1'b0;
            tail_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (accept_c) tail_d = ~tail_q;
            if (pop_c)    head_d = ~head_q;
            case ({accept_c, pop_c})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (accept_c && legal_c && in_setflags) flags_d = {in_zout, in_n, in_v};
            br_taken_d = accept_c && legal_c && br_cond_c;
            illegal_d  = accept_c && !legal_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            flags_q    <= 3'b000;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flags_q    <= flags_d;
            br_taken_q <= br_taken_d;
            illegal_q  <= illegal_d;
        end
    end

    // Entry storage; written only on accept so empty slots keep stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
        end else if (accept_c) begin
            mem_q[tail_q] <= new_entry_c;
        end
    end

`ifdef STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Set has priority over clear; flush leaves the sticky bit alone.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_clr) sticky_d = 1'b0;
        if (accept_c && legal_c && in_v) sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Execute-to-memory boundary stage directly downstream of the 32-bit ALU. Captures each ALU result and its zero/negative/overflow flags into a 2-entry skid buffer with a valid/ready handshake and resolves conditional branches from those flags. Maintains the architectural flag register. Decouples a back-pressuring memory stage from the combinational ALU.

## Interface
- WIDTH, 32, ALU result width
- RDW, 5, destination register index width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept an entry
- in_sum  input  WIDTH  ALU result
- in_zout  input  1  ALU zero flag
- in_n  input  1  ALU negative flag
- in_v  input  1  ALU overflow flag
- in_gin  input  3  ALU control code used for this result
- in_rd  input  RDW  destination register
- in_regwrite  input  1  result is written back
- in_setflags  input  1  entry updates the flag register
- in_br  input  3  branch type: 000 none, 001 eq (Z), 010 ne (!Z), 011 lt (N), 100 ovf (V), others none
- flush  input  1  synchronous discard of all held and incoming entries
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head
- out_sum  output  WIDTH  head result
- out_rd  output  RDW  head destination
- out_regwrite  output  1  head write-enable, forced 0 for illegal gin
- flags_q  output  3  architectural flags {Z,N,V}
- br_taken  output  1  one-cycle pulse, branch condition true
- illegal_op  output  1  one-cycle pulse, accepted entry had illegal gin

## Operation
- Storage: 2 entries, head/tail pointers (1 bit each), count 0..2.
- Accept = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != 2), combinational from state only; never depends on in_valid.
- out_valid = (count != 0); out_* driven from head entry.
- Accept and pop in same cycle: count unchanged, both pointers advance (wrap 1->0).
- Legal gin: 000, 001, 010, 110, 111. Other codes: entry stored with regwrite=0, illegal_op pulses, flags_q and branch unaffected.
- Flag register: on accept with in_setflags and legal gin, flags_q <= {in_zout,in_n,in_v}.
- Branch: on accept with legal gin, condition evaluated from the incoming flags per in_br; registered result drives br_taken.
- Flush: count, pointers -> 0; an entry offered in the flush cycle is not accepted (in_ready still reflects state, but accept is ignored); br_taken/illegal_op pulses for that cycle suppressed; flags_q retained.

## Timing
- Reset (rst_n low, asynchronous): count=0, pointers=0, out_valid=0, in_ready=1, flags_q=3'b000, br_taken=0, illegal_op=0, out_sum/out_rd/out_regwrite=0.
- Latency: entry accepted at edge k is visible on out_* with out_valid=1 after edge k; br_taken/illegal_op high for exactly the cycle after edge k.
- Full throughput: one entry per cycle with out_ready held high.
- Full (count=2): in_ready=0; pop in that cycle raises in_ready the next cycle.
- Empty: out_valid=0, out_* hold last-written entry values (don't-care).
- Reset assertion mid-transfer discards all entries immediately; release takes effect at next edge.

## Configuration
- STICKY_OVF_EN defined: adds ports ovf_sticky (output, 1) and ovf_clr (input, 1); ovf_sticky sets on any accepted legal entry with in_v=1 (regardless of in_setflags), clears on ovf_clr, set wins if both in one cycle; reset 0; flush does not clear it.
- Undefined: ports absent, no sticky logic.

## Test plan
- Reset then in_valid with in_sum=32'h0000_0005, gin=010, out_ready=1 -> out_valid next cycle, out_sum=5, in_ready stays 1.
- out_ready=0, three back-to-back entries A,B,C -> A,B held, in_ready=0 after second, C not accepted; out_ready=1 -> A then B popped in order, in_ready returns to 1.
- Accept in_zout=1, in_br=001, in_setflags=1 -> br_taken one-cycle pulse, flags_q=3'b100; same with in_br=010 -> no pulse.
- Accept gin=011, in_regwrite=1, in_br=001, in_zout=1 -> illegal_op pulse, out_regwrite=0, no br_taken, flags_q unchanged.
- Two entries held, flush with in_valid=1 -> next cycle out_valid=0, count 0, offered entry lost, flags_q unchanged.
- STICKY_OVF_EN: accept in_v=1 with in_setflags=0 -> ovf_sticky=1; ovf_clr and another in_v=1 accept same cycle -> stays 1; ovf_clr alone -> 0.
